// File: rtl/cc_stream_xor.sv
// Keystream XOR stage behind the ChaCha20 block core: requests one 512-bit
// block per 16 words, XORs the input stream and presents it through a skid register.
module cc_stream_xor (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_init,
    input  logic [31:0]  i_cnt0,
    output logic         o_blk_start,
    output logic [31:0]  o_blk_cnt,
    input  logic         i_blk_done,
    input  logic [511:0] i_blk_stream,
    input  logic         i_valid,
    output logic         o_in_ready,
    input  logic [31:0]  i_data,
    input  logic [3:0]   i_keep,
    input  logic         i_last,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [31:0]  o_data,
    output logic [3:0]   o_keep,
    output logic         o_last,
    output logic         o_busy,
    output logic         o_cnt_ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CAP,
        S_XOR
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [511:0]  r_ks;
    logic [31:0]   r_cnt;
    logic [3:0]    r_widx;
    logic          r_cnt_ovf;
    logic [31:0]   r_data;
    logic [3:0]    r_keep;
    logic          r_last;
    logic          r_valid;

    logic [31:0]   w_ks_words [16];
    logic [3:0]    w_keep_eff;
    logic [31:0]   w_mask;
    logic [31:0]   w_xor;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_blk_start;
    logic          w_busy;

    // Word 0 of the core stream sits in the most significant 32 bits.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_ks_word
            assign w_ks_words[gi] = r_ks[511-32*gi -: 32];
        end
        for (gi = 0; gi < 4; gi++) begin : g_byte_mask
            assign w_mask[8*gi +: 8] = {8{w_keep_eff[gi]}};
        end
    endgenerate

    assign w_keep_eff = i_last ? i_keep : 4'hF;
    assign w_in_ready = (r_state == S_XOR) && (!r_valid || i_ready);
    assign w_accept   = w_in_ready && i_valid;
    assign w_xor      = (i_data ^ w_ks_words[r_widx]) & w_mask;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_blk_start  = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (i_init) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                w_blk_start  = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (i_blk_done) begin
                    w_state_next = S_CAP;
                end
            end
            S_CAP: begin
                w_state_next = S_XOR;
            end
            S_XOR: begin
                // A last word ends the message even when it is also word 15.
                if (w_accept) begin
                    if (i_last) begin
                        w_state_next = S_IDLE;
                    end else if (r_widx == 4'd15) begin
                        w_state_next = S_REQ;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_ks      <= '0;
            r_cnt     <= '0;
            r_widx    <= '0;
            r_cnt_ovf <= 1'b0;
            r_data    <= '0;
            r_keep    <= '0;
            r_last    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_init) begin
                r_cnt     <= i_cnt0;
                r_cnt_ovf <= 1'b0;
            end
            if (r_state == S_CAP) begin
                r_ks   <= i_blk_stream;
                r_widx <= '0;
            end
            if (w_accept) begin
                r_data  <= w_xor;
                r_keep  <= w_keep_eff;
                r_last  <= i_last;
                r_valid <= 1'b1;
                r_widx  <= r_widx + 4'd1;
                if (!i_last && r_widx == 4'd15) begin
                    r_cnt <= r_cnt + 32'd1;
                    if (r_cnt == 32'hFFFF_FFFF) begin
                        r_cnt_ovf <= 1'b1;
                    end
                end
            end else if (i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_blk_start = w_blk_start;
    assign o_blk_cnt   = r_cnt;
    assign o_in_ready  = w_in_ready;
    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_keep      = r_keep;
    assign o_last      = r_last;
    assign o_busy      = w_busy;
    assign o_cnt_ovf   = r_cnt_ovf;

endmodule

// File: tb/tb_cc_stream_xor.sv
// Bench for cc_stream_xor: a stand-in block core, a randomised ready driver and
// a word-level reference model (word n uses block cnt0 + n/16, word n % 16).
module tb_cc_stream_xor;

    logic         clk = 1'b0;
    logic         i_rstn;
    logic         i_init;
    logic [31:0]  i_cnt0;
    logic         o_blk_start;
    logic [31:0]  o_blk_cnt;
    logic         i_blk_done = 1'b0;
    logic [511:0] i_blk_stream = '0;
    logic         i_valid;
    logic         o_in_ready;
    logic [31:0]  i_data;
    logic [3:0]   i_keep;
    logic         i_last;
    logic         o_valid;
    logic         i_ready = 1'b1;
    logic [31:0]  o_data;
    logic [3:0]   o_keep;
    logic         o_last;
    logic         o_busy;
    logic         o_cnt_ovf;

    int checks = 0;
    int errors = 0;

    cc_stream_xor dut (
        .i_clk        (clk),
        .i_rstn       (i_rstn),
        .i_init       (i_init),
        .i_cnt0       (i_cnt0),
        .o_blk_start  (o_blk_start),
        .o_blk_cnt    (o_blk_cnt),
        .i_blk_done   (i_blk_done),
        .i_blk_stream (i_blk_stream),
        .i_valid      (i_valid),
        .o_in_ready   (o_in_ready),
        .i_data       (i_data),
        .i_keep       (i_keep),
        .i_last       (i_last),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_keep       (o_keep),
        .o_last       (o_last),
        .o_busy       (o_busy),
        .o_cnt_ovf    (o_cnt_ovf)
    );

    always #5 clk = ~clk;

    // Keystream word k of block cnt; block 0 is RFC 8439 A.1 vector 1 (zero key/nonce).
    function automatic logic [31:0] ks_word(input logic [31:0] cnt, input int k);
        logic [31:0] x;
        if (cnt == 32'd0) begin
            case (k)
                0:  return 32'hade0b876;
                1:  return 32'h903df1a0;
                2:  return 32'he56a5d40;
                3:  return 32'h28bd8653;
                4:  return 32'hb819d2bd;
                5:  return 32'h1aed8da0;
                6:  return 32'hccef36a8;
                7:  return 32'hc70d778b;
                8:  return 32'h7c5941da;
                9:  return 32'h8d485751;
                10: return 32'h3fe02477;
                11: return 32'h374ad8b8;
                12: return 32'hf4b8436a;
                13: return 32'h1ca11815;
                14: return 32'h69b687c3;
                default: return 32'h8665eeb2;
            endcase
        end
        x = cnt * 32'h9E3779B9 + 32'(k) * 32'h7F4A7C15;
        x = x ^ (x >> 15);
        x = x * 32'h2C1B3C6D;
        x = x ^ (x >> 12);
        return x;
    endfunction

    function automatic logic [511:0] make_stream(input logic [31:0] cnt);
        logic [511:0] s;
        s = '0;
        for (int k = 0; k < 16; k++) s[511-32*k -: 32] = ks_word(cnt, k);
        return s;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] c0, input int n,
                                             input logic [31:0] d, input logic [3:0] k);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
        return (d ^ ks_word(c0 + 32'(n / 16), n % 16)) & m;
    endfunction

    // Stand-in core: not reset, so a done pulse can arrive after the DUT was reset.
    int           core_lat = 2;
    logic         core_busy = 1'b0;
    logic         pend_stream = 1'b0;
    int           lat_cnt = 0;
    logic [31:0]  core_cnt = '0;
    logic [31:0]  starts [$];
    int           cnt_unstable = 0;

    always @(posedge clk) begin
        i_blk_done <= 1'b0;
        if (pend_stream) begin
            i_blk_stream <= make_stream(core_cnt);
            pend_stream  <= 1'b0;
        end
        if (core_busy) begin
            if (lat_cnt == 0) begin
                i_blk_done  <= 1'b1;
                core_busy   <= 1'b0;
                pend_stream <= 1'b1;
                if (o_blk_cnt !== core_cnt && o_busy) cnt_unstable <= cnt_unstable + 1;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
        if (o_blk_start === 1'b1) begin
            core_busy    <= 1'b1;
            core_cnt     <= o_blk_cnt;
            lat_cnt      <= core_lat;
            i_blk_stream <= {16{32'hDEADBEEF}};
            starts.push_back(o_blk_cnt);
        end
    end

    // Output side: 0 = always ready, 1 = random, 2 = never ready.
    int           ready_mode = 0;
    logic [31:0]  rx_data [$];
    logic [3:0]   rx_keep [$];
    logic         rx_last [$];
    int           stab_viol = 0;
    logic         held = 1'b0;
    logic [31:0]  held_data = '0;

    initial begin
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       i_ready = 1'b1;
                1:       i_ready = 1'($urandom_range(0, 1));
                default: i_ready = 1'b0;
            endcase
            #1;
            if (held && (o_valid !== 1'b1 || o_data !== held_data)) stab_viol++;
            held      = o_valid && !i_ready;
            held_data = o_data;
            if (i_rstn && o_valid && i_ready) begin
                rx_data.push_back(o_data);
                rx_keep.push_back(o_keep);
                rx_last.push_back(o_last);
            end
        end
    end

    logic [31:0] tx_data [$];
    logic [3:0]  tx_keep [$];
    int          tx_timeouts = 0;

    task automatic clear_queues();
        rx_data.delete(); rx_keep.delete(); rx_last.delete();
        tx_data.delete(); tx_keep.delete(); starts.delete();
        tx_timeouts = 0; stab_viol = 0; cnt_unstable = 0;
    endtask

    task automatic start_msg(input logic [31:0] c0);
        @(negedge clk); #1;
        i_init = 1'b1; i_cnt0 = c0;
        @(negedge clk); #1;
        i_init = 1'b0;
    endtask

    task automatic send_words(input int n, input logic [3:0] lkeep, input bit gaps, input bit zero);
        for (int w = 0; w < n; w++) begin
            int t;
            if (gaps) repeat ($urandom_range(0, 2)) begin @(negedge clk); #1; end
            i_valid = 1'b1;
            i_data  = zero ? 32'd0 : $urandom;
            i_last  = (w == n - 1);
            i_keep  = (w == n - 1) ? lkeep : 4'hF;
            tx_data.push_back(i_data);
            tx_keep.push_back(i_keep);
            t = 0;
            while (!o_in_ready && t < 3000) begin @(negedge clk); #1; t++; end
            if (t >= 3000) begin tx_timeouts++; i_valid = 1'b0; break; end
            @(negedge clk); #1;
            i_valid = 1'b0;
            i_last  = 1'b0;
        end
    endtask

    task automatic wait_rx(input int n);
        int t = 0;
        while ((rx_data.size() < n || o_busy) && t < 3000) begin @(negedge clk); #1; t++; end
        repeat (4) begin @(negedge clk); #1; end
    endtask

    task automatic test_reset();
        i_rstn = 1'b0; i_init = 1'b0; i_cnt0 = 32'h1234_5678;
        i_valid = 1'b0; i_data = '0; i_keep = 4'hF; i_last = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({o_blk_start, o_in_ready, o_valid, o_last, o_busy, o_cnt_ovf} !== 6'b0 ||
            o_data !== 32'd0 || o_keep !== 4'd0 || o_blk_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs got flags=%b data=%h keep=%h cnt=%h required all zero",
                     {o_blk_start, o_in_ready, o_valid, o_last, o_busy, o_cnt_ovf}, o_data, o_keep, o_blk_cnt);
        end
        i_rstn = 1'b1;
        repeat (2) begin @(negedge clk); #1; end
        checks++;
        if (o_busy !== 1'b0 || o_blk_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle got busy=%b start=%b required 0 0", o_busy, o_blk_start);
        end
        $display("test_reset done");
    endtask

    task automatic test_rfc_vector();
        int t;
        clear_queues();
        ready_mode = 0; core_lat = 3;
        start_msg(32'd0);
        checks++;
        if (o_blk_start !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL rfc_start_timing got start=%b busy=%b required 1 1", o_blk_start, o_busy);
        end
        @(negedge clk); #1;
        checks++;
        if (o_blk_start !== 1'b0) begin
            errors++;
            $display("FAIL rfc_start_width got start=%b required 0", o_blk_start);
        end
        t = 0;
        while (!i_blk_done && t < 200) begin @(negedge clk); #1; t++; end
        @(negedge clk); #1;
        checks++;
        if (o_in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rfc_ready_cap got %b required 0", o_in_ready);
        end
        @(negedge clk); #1;
        checks++;
        if (o_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rfc_ready_xor got %b required 1", o_in_ready);
        end
        send_words(16, 4'hF, 1'b0, 1'b1);
        wait_rx(16);
        checks++;
        if (rx_data.size() != 16 || tx_timeouts != 0) begin
            errors++;
            $display("FAIL rfc_count got %0d words timeouts=%0d required 16 0", rx_data.size(), tx_timeouts);
        end else begin
            checks++;
            if (rx_data[0] !== 32'hade0b876 || rx_data[1] !== 32'h903df1a0) begin
                errors++;
                $display("FAIL rfc_words01 got %h %h required ade0b876 903df1a0", rx_data[0], rx_data[1]);
            end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (rx_data[i] !== exp_word(32'd0, i, 32'd0, 4'hF) || rx_last[i] !== (i == 15)) begin
                    errors++;
                    $display("FAIL rfc_word%0d got %h last=%b required %h last=%b", i, rx_data[i],
                             rx_last[i], exp_word(32'd0, i, 32'd0, 4'hF), (i == 15));
                end
            end
        end
        checks++;
        if (starts.size() != 1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rfc_single_start got starts=%0d busy=%b required 1 0", starts.size(), o_busy);
        end
        $display("test_rfc_vector done");
    endtask

    task automatic test_multi_block();
        logic [31:0] c0;
        clear_queues();
        ready_mode = 0; core_lat = 4;
        c0 = $urandom & 32'h7FFF_FFFF;
        start_msg(c0);
        send_words(40, 4'hF, 1'b0, 1'b0);
        wait_rx(40);
        checks++;
        if (starts.size() != 3 || tx_timeouts != 0) begin
            errors++;
            $display("FAIL multi_starts got %0d timeouts=%0d required 3 0", starts.size(), tx_timeouts);
        end else begin
            for (int j = 0; j < 3; j++) begin
                checks++;
                if (starts[j] !== c0 + 32'(j)) begin
                    errors++;
                    $display("FAIL multi_blk_cnt%0d got %h required %h", j, starts[j], c0 + 32'(j));
                end
            end
        end
        checks++;
        if (rx_data.size() != 40) begin
            errors++;
            $display("FAIL multi_count got %0d required 40", rx_data.size());
        end else begin
            for (int i = 0; i < 40; i++) begin
                checks++;
                if (rx_data[i] !== exp_word(c0, i, tx_data[i], 4'hF) || rx_last[i] !== (i == 39)) begin
                    errors++;
                    $display("FAIL multi_word%0d got %h last=%b required %h last=%b", i, rx_data[i],
                             rx_last[i], exp_word(c0, i, tx_data[i], 4'hF), (i == 39));
                end
            end
        end
        checks++;
        if (o_cnt_ovf !== 1'b0 || cnt_unstable != 0) begin
            errors++;
            $display("FAIL multi_ovf_cnt got ovf=%b unstable=%0d required 0 0", o_cnt_ovf, cnt_unstable);
        end
        $display("test_multi_block done");
    endtask

    task automatic test_partial_last();
        logic [31:0] c0;
        clear_queues();
        ready_mode = 0; core_lat = 1;
        c0 = $urandom & 32'h7FFF_FFFF;
        start_msg(c0);
        send_words(5, 4'b0011, 1'b0, 1'b0);
        wait_rx(5);
        checks++;
        if (rx_data.size() != 5) begin
            errors++;
            $display("FAIL partial_count got %0d required 5", rx_data.size());
        end else begin
            checks++;
            if (rx_data[4][31:16] !== 16'd0 || rx_keep[4] !== 4'b0011 || rx_last[4] !== 1'b1) begin
                errors++;
                $display("FAIL partial_last got data=%h keep=%b last=%b required upper 0 keep 0011 last 1",
                         rx_data[4], rx_keep[4], rx_last[4]);
            end
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (rx_data[i] !== exp_word(c0, i, tx_data[i], tx_keep[i])) begin
                    errors++;
                    $display("FAIL partial_word%0d got %h required %h", i, rx_data[i],
                             exp_word(c0, i, tx_data[i], tx_keep[i]));
                end
            end
        end
        $display("test_partial_last done");
    endtask

    task automatic test_backpressure();
        logic [31:0] c0;
        logic [3:0]  lk;
        int          n;
        clear_queues();
        ready_mode = 1; core_lat = $urandom_range(0, 6);
        c0 = $urandom & 32'h7FFF_FFFF;
        n  = $urandom_range(20, 50);
        lk = 4'($urandom_range(1, 15));
        start_msg(c0);
        send_words(n, lk, 1'b1, 1'b0);
        wait_rx(n);
        ready_mode = 0;
        checks++;
        if (rx_data.size() != n || tx_timeouts != 0) begin
            errors++;
            $display("FAIL bp_count got %0d timeouts=%0d required %0d 0", rx_data.size(), tx_timeouts, n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (rx_data[i] !== exp_word(c0, i, tx_data[i], tx_keep[i]) ||
                    rx_keep[i] !== tx_keep[i] || rx_last[i] !== (i == n - 1)) begin
                    errors++;
                    $display("FAIL bp_word%0d got %h keep=%h last=%b required %h keep=%h last=%b", i,
                             rx_data[i], rx_keep[i], rx_last[i], exp_word(c0, i, tx_data[i], tx_keep[i]),
                             tx_keep[i], (i == n - 1));
                end
            end
        end
        checks++;
        if (stab_viol != 0) begin
            errors++;
            $display("FAIL bp_stable got %0d violations required 0", stab_viol);
        end
        checks++;
        if (starts.size() != (n + 15) / 16) begin
            errors++;
            $display("FAIL bp_starts got %0d required %0d", starts.size(), (n + 15) / 16);
        end
        $display("test_backpressure done n=%0d", n);
    endtask

    task automatic test_counter_wrap();
        clear_queues();
        ready_mode = 0; core_lat = 2;
        start_msg(32'hFFFF_FFFF);
        send_words(20, 4'hF, 1'b0, 1'b0);
        wait_rx(20);
        checks++;
        if (starts.size() != 2) begin
            errors++;
            $display("FAIL wrap_starts got %0d required 2", starts.size());
        end else begin
            checks++;
            if (starts[0] !== 32'hFFFF_FFFF || starts[1] !== 32'd0) begin
                errors++;
                $display("FAIL wrap_blk_cnt got %h %h required ffffffff 00000000", starts[0], starts[1]);
            end
        end
        checks++;
        if (rx_data.size() != 20) begin
            errors++;
            $display("FAIL wrap_count got %0d required 20", rx_data.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                checks++;
                if (rx_data[i] !== exp_word(32'hFFFF_FFFF, i, tx_data[i], 4'hF)) begin
                    errors++;
                    $display("FAIL wrap_word%0d got %h required %h", i, rx_data[i],
                             exp_word(32'hFFFF_FFFF, i, tx_data[i], 4'hF));
                end
            end
        end
        checks++;
        if (o_cnt_ovf !== 1'b1) begin
            errors++;
            $display("FAIL wrap_ovf_set got %b required 1", o_cnt_ovf);
        end
        repeat (5) begin @(negedge clk); #1; end
        checks++;
        if (o_cnt_ovf !== 1'b1) begin
            errors++;
            $display("FAIL wrap_ovf_sticky got %b required 1", o_cnt_ovf);
        end
        clear_queues();
        start_msg(32'd5);
        checks++;
        if (o_cnt_ovf !== 1'b0) begin
            errors++;
            $display("FAIL wrap_ovf_clear got %b required 0", o_cnt_ovf);
        end
        send_words(3, 4'hF, 1'b0, 1'b0);
        wait_rx(3);
        checks++;
        if (rx_data.size() != 3 || rx_data[0] !== exp_word(32'd5, 0, tx_data[0], 4'hF)) begin
            errors++;
            $display("FAIL wrap_next_msg got %0d words required 3 matching", rx_data.size());
        end
        $display("test_counter_wrap done");
    endtask

    task automatic test_reset_mid();
        logic [31:0] c0;
        clear_queues();
        ready_mode = 2; core_lat = 1;
        start_msg($urandom | 32'h1);
        send_words(1, 4'b0110, 1'b0, 1'b0);
        core_lat = 10;
        start_msg($urandom | 32'h1);
        @(negedge clk); #1;
        i_rstn = 1'b0;
        @(negedge clk); #1;
        i_rstn = 1'b1;
        checks++;
        if ({o_blk_start, o_in_ready, o_valid, o_last, o_busy, o_cnt_ovf} !== 6'b0 ||
            o_data !== 32'd0 || o_keep !== 4'd0 || o_blk_cnt !== 32'd0) begin
            errors++;
            $display("FAIL midrst_outputs got flags=%b data=%h keep=%h cnt=%h required all zero",
                     {o_blk_start, o_in_ready, o_valid, o_last, o_busy, o_cnt_ovf}, o_data, o_keep, o_blk_cnt);
        end
        ready_mode = 0;
        repeat (20) begin @(negedge clk); #1; end
        checks++;
        if (o_busy !== 1'b0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_stray_done got busy=%b valid=%b required 0 0", o_busy, o_valid);
        end
        clear_queues();
        core_lat = 2;
        c0 = $urandom & 32'h7FFF_FFFF;
        start_msg(c0);
        send_words(5, 4'hF, 1'b0, 1'b0);
        wait_rx(5);
        checks++;
        if (rx_data.size() != 5 || starts.size() != 1) begin
            errors++;
            $display("FAIL midrst_fresh_count got %0d words %0d starts required 5 1", rx_data.size(), starts.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (rx_data[i] !== exp_word(c0, i, tx_data[i], 4'hF)) begin
                    errors++;
                    $display("FAIL midrst_word%0d got %h required %h", i, rx_data[i],
                             exp_word(c0, i, tx_data[i], 4'hF));
                end
            end
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_rfc_vector();
        test_multi_block();
        test_partial_last();
        test_backpressure();
        test_counter_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
